// File: rtl/icache_pkg.sv
// Shared widths and FSM encodings for the direct-mapped instruction cache.
package icache_pkg;
  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one write port, one combinational read port.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_idx,
  input  logic [TAG_BITS-1:0]   w_tag,
  input  logic [INST_LEN-1:0]   w_data,
  input  logic [INDEX_BITS-1:0] r_idx,
  output logic                  r_valid,
  output logic [TAG_BITS-1:0]   r_tag,
  output logic [INST_LEN-1:0]   r_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [INST_LEN-1:0] data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid        <= '0;
    else if (we) valid[w_idx] <= 1'b1;
  end

  // Tag/data need no reset: a line is only read through its valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[w_idx] <= w_tag;
      data[w_idx] <= w_data;
    end
  end

  assign r_valid = valid[r_idx];
  assign r_tag   = tags[r_idx];
  assign r_data  = data[r_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-line instruction cache with 0-cycle hits and refill bypass.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 18 - INDEX_BITS - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                fetch_req_i,
  input  logic [ADDR_LEN-1:0] fetch_pc_i,
  input  logic                jump_i,
  output logic                inst_ready_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic                hit_o,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  input  logic                mem_ready_i,
  input  logic [INST_LEN-1:0] mem_inst_i
);
  logic [0:0]            state;
  logic [ADDR_LEN-3:0]   miss_pc;
  logic                  r_valid;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INST_LEN-1:0]   r_data;
  logic                  is_miss, hit, fill, fill_fwd;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = ^fetch_pc_i[1:0];

  icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (rdy & fill),
    .w_idx  (miss_pc[INDEX_BITS-1:0]),
    .w_tag  (miss_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS]),
    .w_data (mem_inst_i),
    .r_idx  (fetch_pc_i[INDEX_BITS+1:2]),
    .r_valid(r_valid),
    .r_tag  (r_tag),
    .r_data (r_data)
  );

  assign is_miss  = (state == S_MISS);
  assign hit      = !is_miss && fetch_req_i && r_valid &&
                    (r_tag == fetch_pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
  // A refill landing with a redirect still fills the array but is not forwarded.
  assign fill     = is_miss && mem_ready_i;
  assign fill_fwd = fill && !jump_i;

  assign hit_o        = hit;
  assign inst_ready_o = rdy && (hit || fill_fwd);
  assign inst_o       = hit ? r_data : (fill_fwd ? mem_inst_i : '0);
  assign mem_req_o    = is_miss;
  assign mem_addr_o   = is_miss ? {miss_pc, 2'b00} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      miss_pc <= '0;
    end else if (rdy) begin
      case (state)
        S_IDLE: if (fetch_req_i && !hit && !jump_i) begin
          state   <= S_MISS;
          miss_pc <= fetch_pc_i[ADDR_LEN-1:2];
        end
        S_MISS: if (mem_ready_i || jump_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache.sv
// Random + directed bench for icache against a line-level reference model.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, fetch_req_i, jump_i, mem_ready_i;
  logic [31:0] fetch_pc_i, mem_inst_i;
  logic        inst_ready_o, hit_o, mem_req_o;
  logic [31:0] inst_o, mem_addr_o;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_req_i(fetch_req_i), .fetch_pc_i(fetch_pc_i), .jump_i(jump_i),
    .inst_ready_o(inst_ready_o), .inst_o(inst_o), .hit_o(hit_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_inst_i(mem_inst_i)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  // Reference: per line, which word address (pc[17:2]) it holds and its word.
  bit          m_miss;
  logic [31:0] m_addr;
  bit          m_val [128];
  logic [15:0] m_lad [128];
  logic [31:0] m_dat [128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h1234_0001;
  endfunction

  task automatic mdl_reset();
    m_miss = 0;
    m_addr = 0;
    for (int k = 0; k < 128; k++) m_val[k] = 0;
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance model at the edge.
  task automatic tick(input logic req, input logic [31:0] pc, input logic jmp,
                      input logic mrdy, input logic [31:0] minst, input logic r);
    logic ehit;
    int   i;
    fetch_req_i = req; fetch_pc_i = pc; jump_i = jmp;
    mem_ready_i = mrdy; mem_inst_i = minst; rdy = r;
    #3;
    i    = int'(pc[8:2]);
    ehit = !m_miss && req && m_val[i] && (m_lad[i] == pc[17:2]);
    chk("mem_req", {31'b0, mem_req_o}, {31'b0, m_miss});
    chk("mem_addr", mem_addr_o, m_miss ? m_addr : 32'h0);
    if (!m_miss) begin
      chk("hit", {31'b0, hit_o}, {31'b0, ehit});
      chk("ready_idle", {31'b0, inst_ready_o}, {31'b0, r && ehit});
      if (r && ehit) chk("inst_hit", inst_o, m_dat[i]);
    end else begin
      chk("ready_miss", {31'b0, inst_ready_o}, {31'b0, r && mrdy && !jmp});
      if (r && mrdy && !jmp) chk("inst_fill", inst_o, minst);
    end
    @(posedge clk);
    if (r) begin
      if (!m_miss) begin
        if (req && !ehit && !jmp) begin
          m_miss = 1;
          m_addr = {pc[31:2], 2'b00};
        end
      end else if (mrdy || jmp) begin
        if (mrdy) begin
          i = int'(m_addr[8:2]);
          m_val[i] = 1;
          m_lad[i] = m_addr[17:2];
          m_dat[i] = minst;
        end
        m_miss = 0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    logic        mr;
    rst = 1; rdy = 1; fetch_req_i = 0; fetch_pc_i = 0; jump_i = 0;
    mem_ready_i = 0; mem_inst_i = 0;
    mdl_reset();
    #1;
    chk("rst_ready", {31'b0, inst_ready_o}, 32'h0);
    chk("rst_hit", {31'b0, hit_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_mreq", {31'b0, mem_req_o}, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    tick(0, 32'h0, 0, 0, 32'h0, 1);

    // Cold miss, bypassed refill, then same-cycle hit.
    tick(1, 32'h0, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'h0000_0513, 1);
    tick(1, 32'h0, 0, 0, 32'h0, 1);
    chk("hit_0513", m_dat[0], 32'h0000_0513);

    // Same-index alias evicts the earlier line.
    tick(1, 32'h4, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'hAAAA_0004, 1);
    tick(1, 32'h204, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'hBBBB_0204, 1);
    tick(1, 32'h4, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'hAAAA_0004, 1);

    // Redirect cancels a pending miss.
    tick(1, 32'h100, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 1, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 0, 32'h0, 1);
    tick(1, 32'h100, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, memword(32'h100), 1);

    // Redirect coinciding with refill: filled but not forwarded.
    tick(1, 32'h200, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 1, 1, 32'h1234_5678, 1);
    tick(1, 32'h200, 0, 0, 32'h0, 1);

    // Stall mid-miss, then normal completion.
    tick(1, 32'h300, 0, 0, 32'h0, 1);
    for (int k = 0; k < 3; k++) tick(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    tick(0, 32'h0, 0, 1, 32'hC0DE_0300, 1);
    tick(1, 32'h300, 0, 0, 32'h0, 1);

    // Async reset mid-miss; refill on release ignored; old line lost.
    tick(1, 32'h0, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'h0000_0513, 1);
    tick(1, 32'h8, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 0, 32'h0, 1);
    #2 rst = 1;
    #1;
    chk("arst_mreq", {31'b0, mem_req_o}, 32'h0);
    chk("arst_maddr", mem_addr_o, 32'h0);
    mdl_reset();
    @(posedge clk); #1;
    rst = 0;
    tick(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 1);
    tick(1, 32'h0, 0, 0, 32'h0, 1);
    tick(0, 32'h0, 0, 1, 32'h0000_0513, 1);

    // Randomized traffic over a small address pool to force hits and aliases.
    for (int n = 0; n < 3000; n++) begin
      pc = ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 2) << 9) |
           ($urandom_range(0, 7) << 2) | ($urandom & 32'h3);
      mr = ($urandom_range(0, 2) == 0);
      tick($urandom_range(0, 3) != 0, pc, $urandom_range(0, 7) == 0, mr,
           m_miss ? memword(m_addr) : $urandom, $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, meaning log2 of line count (128 direct-mapped one-word lines).
REQ-002 Parameter TAG_BITS, default 18-INDEX_BITS-2, meaning tag width covering address bits [17:INDEX_BITS+2].
REQ-003 clk  in  1  system clock; one clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rdy  in  1  global ready; low freezes all state.
REQ-006 fetch_req_i  in  1  fetch requests an instruction at fetch_pc_i this cycle.
REQ-007 fetch_pc_i  in  32  fetch address; bits [1:0] ignored.
REQ-008 jump_i  in  1  pipeline redirect; cancels any outstanding miss.
REQ-009 inst_ready_o  out  1  inst_o valid for fetch_pc_i this cycle.
REQ-010 inst_o  out  32  instruction word.
REQ-011 hit_o  out  1  current request hit in the array.
REQ-012 mem_req_o  out  1  refill request to the memory controller.
REQ-013 mem_addr_o  out  32  word-aligned refill address.
REQ-014 mem_ready_i  in  1  memory controller returns refill word this cycle.
REQ-015 mem_inst_i  in  32  refill word.

Function
REQ-016 Index = pc[INDEX_BITS+1:2]; tag = pc[17:INDEX_BITS+2]; bits above 17 ignored.
REQ-017 States: IDLE, MISS; one state register.
REQ-018 IDLE, fetch_req_i, valid[index] and tag match: hit_o=1, inst_ready_o=1, inst_o=data[index] combinationally, same cycle (0-cycle hit latency).
REQ-019 IDLE, fetch_req_i, miss, jump_i=0: next state MISS; latch miss address; hit_o=0, inst_ready_o=0.
REQ-020 MISS: mem_req_o=1, mem_addr_o={latched pc[31:2],2'b00}, held stable until mem_ready_i or cancel.
REQ-021 MISS, mem_ready_i=1, jump_i=0: write data/tag, set valid; inst_ready_o=1 and inst_o=mem_inst_i same cycle (bypass); next IDLE.
REQ-022 MISS, jump_i=1, mem_ready_i=0: next IDLE; no array write; inst_ready_o=0; mem_req_o=0 from next cycle.
REQ-023 MISS, jump_i=1 and mem_ready_i=1 same cycle: array written (data correct), inst_ready_o=0, next IDLE.
REQ-024 IDLE, jump_i=1: no miss started this cycle; hit output still reported (fetch discards it).
REQ-025 mem_req_o=0 in IDLE; mem_addr_o don't-care but driven 0.
REQ-026 rdy=0: state, valid, array and latched address unchanged; inst_ready_o=0, mem_req_o holds its value.
REQ-027 Same-index conflicting refill overwrites old line unconditionally (no replacement choice).
REQ-028 No invalidation port; instruction memory treated read-only after reset.

Reset
REQ-029 rst asserted: state=IDLE, all valid bits=0, latched address=0 immediately, independent of clk and rdy.
REQ-030 During and after reset, until a request: inst_ready_o=0, hit_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0.
REQ-031 Reset mid-MISS aborts refill; any mem_ready_i on the reset-release cycle ignored; data/tag arrays need no reset.

Structure
REQ-032 AddrLen, InstLen, state encodings live in the shared consts header.
REQ-033 One sub-module icache_array (valid/tag/data storage, one write port, one combinational read port) is natural.

Verification
REQ-034 After reset, req pc=0x0000 -> miss, mem_req_o=1, mem_addr_o=0x0; mem_ready_i with 0x00000513 -> inst_ready_o=1, inst_o=0x00000513 that cycle; re-request pc=0x0 -> hit same cycle.
REQ-035 Alias: fill 0x0004, then req 0x0204 (same index, INDEX_BITS=7) -> miss and refill; then req 0x0004 -> miss again.
REQ-036 Miss on 0x0100, jump_i pulsed 2 cycles later before mem_ready_i -> mem_req_o drops next cycle, no inst_ready_o, later req 0x0100 misses.
REQ-037 Miss on 0x0200 with jump_i and mem_ready_i (0x12345678) same cycle -> inst_ready_o=0; later req 0x0200 hits with 0x12345678.
REQ-038 rdy=0 for 3 cycles mid-MISS -> mem_addr_o stable, no state change; rdy=1 then mem_ready_i -> normal completion.
REQ-039 rst asserted asynchronously between edges during MISS -> mem_req_o=0 immediately; previously filled pc 0x0000 misses after release.
